// File: rtl/lfsr_seq_ctrl.sv
// Run controller for an external 20-bit LFSR counter: loads a seed, issues a
// programmed number of step strobes, and records when a target value is seen.
module lfsr_seq_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] seed,
    input  logic [15:0]  step_count,
    input  logic [19:0]  match_value,
    input  logic         pause,
    input  logic         abort,
    input  logic [19:0]  lfsr_in,
    output logic         lfsr_load,
    output logic [127:0] lfsr_seed,
    output logic         lfsr_step,
    output logic         busy,
    output logic         done,
    output logic         match_hit,
    output logic [15:0]  first_match_idx,
    output logic [15:0]  steps_taken
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] count_q;
    logic [19:0] match_q;
    logic        step_en;
    logic        cmp_en;
    logic        last_step;

    // Only reachable while stepping, so steps_taken < count_q and the +1 never wraps.
    assign last_step = (steps_taken + 16'd1) == count_q;

    always_comb begin
        state_nxt = state;
        step_en   = 1'b0;
        cmp_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (abort)               state_nxt = IDLE;
                else if (count_q == '0)  state_nxt = DONE;
                else                     state_nxt = RUN;
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    cmp_en = 1'b1;
                    if (!pause) begin
                        step_en = 1'b1;
                        if (last_step) state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                cmp_en    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The step strobe is gated by pause/abort in the same cycle so a stall or
    // cancel never lets one extra step slip through to the counter.
    assign lfsr_step = step_en;
    assign lfsr_load = (state == LOAD);
    assign busy      = (state == LOAD) || (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            lfsr_seed       <= '0;
            count_q         <= '0;
            match_q         <= '0;
            match_hit       <= 1'b0;
            first_match_idx <= '0;
            steps_taken     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                lfsr_seed       <= seed;
                count_q         <= step_count;
                match_q         <= match_value;
                match_hit       <= 1'b0;
                first_match_idx <= '0;
                steps_taken     <= '0;
            end
            if (step_en)
                steps_taken <= steps_taken + 16'd1;
            // steps_taken here is the number of steps behind the value on lfsr_in.
            if (cmp_en && !match_hit && lfsr_in == match_q) begin
                match_hit       <= 1'b1;
                first_match_idx <= steps_taken;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a small 20-bit Fibonacci LFSR
// (x^20 + x^17 + 1, right shift) standing in for the external counter.
module tb_lfsr_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] seed = '0;
    logic [15:0]  step_count = '0;
    logic [19:0]  match_value = '0;
    logic         pause = 1'b0;
    logic         abort = 1'b0;
    logic [19:0]  lfsr_in;
    logic         lfsr_load;
    logic [127:0] lfsr_seed;
    logic         lfsr_step;
    logic         busy;
    logic         done;
    logic         match_hit;
    logic [15:0]  first_match_idx;
    logic [15:0]  steps_taken;

    int errors = 0;
    int checks = 0;
    int n_step = 0;
    int n_load = 0;
    int n_done = 0;
    logic [19:0] lfsr_r = '0;

    lfsr_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .step_count(step_count),
        .match_value(match_value), .pause(pause), .abort(abort), .lfsr_in(lfsr_in),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step), .busy(busy),
        .done(done), .match_hit(match_hit), .first_match_idx(first_match_idx),
        .steps_taken(steps_taken)
    );

    always #5 clk = ~clk;

    assign lfsr_in = lfsr_r;

    // External LFSR counter: load on lfsr_load, advance on lfsr_step.
    always @(posedge clk) begin
        if (lfsr_load === 1'b1)      lfsr_r <= lfsr_seed[19:0];
        else if (lfsr_step === 1'b1) lfsr_r <= {lfsr_r[0] ^ lfsr_r[3], lfsr_r[19:1]};
    end

    always @(posedge clk) begin
        if (lfsr_step === 1'b1) n_step++;
        if (lfsr_load === 1'b1) n_load++;
        if (done === 1'b1)      n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_step = 0;
        n_load = 0;
        n_done = 0;
    endtask

    // Present a start for one cycle; returns with the DUT in LOAD.
    task automatic start_run(input logic [127:0] s, input logic [15:0] c, input logic [19:0] m);
        seed = s; step_count = c; match_value = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Ticks until done is seen or the budget runs out; cyc is the tick count.
    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, done, lfsr_load, lfsr_step, match_hit} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, lfsr_load, lfsr_step, match_hit});
        end
        checks++;
        if ({first_match_idx, steps_taken} !== 32'h0) begin
            errors++; $display("FAIL reset_counts: got %h want 0", {first_match_idx, steps_taken});
        end
        checks++;
        if (lfsr_seed !== 128'h0) begin
            errors++; $display("FAIL reset_seed: got %h want 0", lfsr_seed);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_step();
        int cyc;
        clr_counts();
        start_run(128'h1, 16'd1, 20'h80000);
        checks++;
        if (lfsr_load !== 1'b1 || lfsr_seed !== 128'h1 || busy !== 1'b1) begin
            errors++; $display("FAIL single_load: got load=%b seed=%h busy=%b want 1/1/1", lfsr_load, lfsr_seed, busy);
        end
        wait_done(10, cyc);
        checks++;
        if (cyc !== 2) begin
            errors++; $display("FAIL single_latency: got %0d want 2", cyc);
        end
        tick();
        checks++;
        if (match_hit !== 1'b1 || first_match_idx !== 16'd1 || steps_taken !== 16'd1) begin
            errors++; $display("FAIL single_result: got hit=%b idx=%0d steps=%0d want 1/1/1", match_hit, first_match_idx, steps_taken);
        end
        checks++;
        if (n_step !== 1 || n_load !== 1 || n_done !== 1) begin
            errors++; $display("FAIL single_strobes: got step=%0d load=%0d done=%0d want 1/1/1", n_step, n_load, n_done);
        end
    endtask

    task automatic test_match_at_seed();
        int cyc;
        clr_counts();
        start_run(128'h1, 16'd4, 20'h00001);
        wait_done(20, cyc);
        checks++;
        if (cyc !== 5) begin
            errors++; $display("FAIL seed_latency: got %0d want 5", cyc);
        end
        tick();
        checks++;
        if (match_hit !== 1'b1 || first_match_idx !== 16'd0 || steps_taken !== 16'd4 || n_step !== 4) begin
            errors++; $display("FAIL seed_result: got hit=%b idx=%0d steps=%0d nstep=%0d want 1/0/4/4", match_hit, first_match_idx, steps_taken, n_step);
        end
    endtask

    task automatic test_pause();
        int cyc;
        clr_counts();
        start_run(128'h5, 16'd10, 20'h0);
        tick();                  // enter RUN
        tick(); tick(); tick();  // three steps
        pause = 1'b1;
        #1;
        checks++;
        if (lfsr_step !== 1'b0) begin
            errors++; $display("FAIL pause_step: got %b want 0", lfsr_step);
        end
        tick(); tick(); tick();
        checks++;
        if (steps_taken !== 16'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL pause_hold: got steps=%0d busy=%b want 3/1", steps_taken, busy);
        end
        pause = 1'b0;
        wait_done(30, cyc);
        checks++;
        if (cyc + 7 !== 14) begin
            errors++; $display("FAIL pause_latency: got %0d want 14", cyc + 7);
        end
        tick();
        checks++;
        if (steps_taken !== 16'd10 || n_step !== 10 || match_hit !== 1'b0) begin
            errors++; $display("FAIL pause_result: got steps=%0d nstep=%0d hit=%b want 10/10/0", steps_taken, n_step, match_hit);
        end
    endtask

    task automatic test_zero_count();
        int cyc;
        clr_counts();
        start_run(128'h7, 16'd0, 20'h00007);
        wait_done(10, cyc);
        checks++;
        if (cyc !== 1) begin
            errors++; $display("FAIL zero_latency: got %0d want 1", cyc);
        end
        tick();
        checks++;
        if (n_step !== 0 || steps_taken !== 16'd0 || n_done !== 1 || match_hit !== 1'b1 || first_match_idx !== 16'd0) begin
            errors++; $display("FAIL zero_result: got nstep=%0d steps=%0d ndone=%0d hit=%b idx=%0d want 0/0/1/1/0",
                               n_step, steps_taken, n_done, match_hit, first_match_idx);
        end
    endtask

    task automatic test_abort();
        clr_counts();
        // Abort in IDLE is ignored; abort held into LOAD cancels.
        abort = 1'b1;
        start_run(128'h9, 16'd3, 20'h0);
        checks++;
        if (busy !== 1'b1 || lfsr_load !== 1'b1) begin
            errors++; $display("FAIL abort_idle: got busy=%b load=%b want 1/1", busy, lfsr_load);
        end
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || n_step !== 0) begin
            errors++; $display("FAIL abort_load: got busy=%b nstep=%0d want 0/0", busy, n_step);
        end
        clr_counts();
        start_run(128'h1, 16'd20, 20'h80000);
        tick(); tick(); tick();
        seed = 128'hABC; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();          // five steps issued
        abort = 1'b1; pause = 1'b1;
        #1;
        checks++;
        if (lfsr_step !== 1'b0 || lfsr_seed !== 128'h1) begin
            errors++; $display("FAIL abort_cycle: got step=%b seed=%h want 0/1", lfsr_step, lfsr_seed);
        end
        tick();
        abort = 1'b0; pause = 1'b0;
        checks++;
        if (busy !== 1'b0 || steps_taken !== 16'd5 || n_step !== 5) begin
            errors++; $display("FAIL abort_run: got busy=%b steps=%0d nstep=%0d want 0/5/5", busy, steps_taken, n_step);
        end
        tick(); tick(); tick();
        checks++;
        if (n_done !== 0 || match_hit !== 1'b1 || first_match_idx !== 16'd1 || steps_taken !== 16'd5) begin
            errors++; $display("FAIL abort_after: got ndone=%0d hit=%b idx=%0d steps=%0d want 0/1/1/5",
                               n_done, match_hit, first_match_idx, steps_taken);
        end
    endtask

    task automatic test_rst_mid_run();
        int cyc;
        clr_counts();
        start_run(128'h3, 16'd20, 20'h0);
        tick(); tick(); tick();
        rst = 1'b1; start = 1'b1; pause = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; pause = 1'b0;
        checks++;
        if ({busy, lfsr_step, lfsr_load, done, match_hit} !== 5'b0 || steps_taken !== 16'd0 || lfsr_seed !== 128'h0) begin
            errors++; $display("FAIL rst_mid: got flags=%b steps=%0d seed=%h want 0/0/0",
                               {busy, lfsr_step, lfsr_load, done, match_hit}, steps_taken, lfsr_seed);
        end
        clr_counts();
        start_run(128'h1, 16'd2, 20'h80000);
        wait_done(10, cyc);
        tick();
        checks++;
        if (cyc !== 3 || steps_taken !== 16'd2 || match_hit !== 1'b1 || first_match_idx !== 16'd1) begin
            errors++; $display("FAIL rst_restart: got cyc=%0d steps=%0d hit=%b idx=%0d want 3/2/1/1",
                               cyc, steps_taken, match_hit, first_match_idx);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        clr_counts();
        start_run(128'h1, 16'd2, 20'h0);
        start = 1'b1;            // held through the run, re-accepted in IDLE
        wait_done(10, cyc);
        tick();
        checks++;
        if (lfsr_load !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got load=%b busy=%b want 0/0", lfsr_load, busy);
        end
        tick();
        start = 1'b0;
        checks++;
        if (lfsr_load !== 1'b1 || n_load !== 1 || steps_taken !== 16'd0) begin
            errors++; $display("FAIL b2b_reload: got load=%b nload=%0d steps=%0d want 1/1/0", lfsr_load, n_load, steps_taken);
        end
        wait_done(10, cyc);
        tick();
    endtask

    task automatic test_max_count();
        int cyc;
        clr_counts();
        start_run(128'h1, 16'hFFFF, 20'h0);
        wait_done(70000, cyc);
        checks++;
        if (cyc !== 65536) begin
            errors++; $display("FAIL max_latency: got %0d want 65536", cyc);
        end
        tick(); tick();
        checks++;
        if (steps_taken !== 16'hFFFF || n_step !== 65535 || match_hit !== 1'b0) begin
            errors++; $display("FAIL max_result: got steps=%h nstep=%0d hit=%b want ffff/65535/0", steps_taken, n_step, match_hit);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_match_at_seed();
        test_pause();
        test_zero_count();
        test_abort();
        test_rst_mid_run();
        test_back_to_back();
        test_max_count();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
